// File: rtl/decrypt_rx_param.sv
// Serial key load, pulse-width symbol decode and square-and-multiply message^d mod N.
// Defining DECRX_ERRCNT_EN adds a saturating 8-bit err_cnt output.
module decrypt_rx_param #(
    parameter int unsigned A       = 5,
    parameter int unsigned SYM_MIN = 10,
    parameter int unsigned SYM_MAX = 60,
    parameter int unsigned CW      = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              str,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2**A-1:0]   out_data,
    output logic [3:0]        out_n,
    output logic              busy,
`ifdef DECRX_ERRCNT_EN
    output logic [7:0]        err_cnt,
`endif
    output logic              err
);

    localparam int unsigned D_W = 2**A;
    localparam int unsigned KW  = 4 + 2 * D_W;
    localparam int unsigned LCW = $clog2(KW + 1);
    localparam int unsigned BCW = A + 1;
    localparam int unsigned SW  = CW + 1;
    localparam logic [SW-1:0] SymMinW = SW'(SYM_MIN);
    localparam logic [SW-1:0] SymMaxW = SW'(SYM_MAX);

    typedef enum logic [2:0] {
        StIdle, StLoad, StWaitMsg, StRxMsg, StExp, StOut
    } state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    key_q, key_d;
    logic [LCW-1:0]   ld_cnt_q, ld_cnt_d;
    logic [CW-1:0]    c1_q, c1_d, c0_q, c0_d;
    logic             low_q, low_d;
    logic [D_W-1:0]   data_q, data_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [D_W-1:0]   r_q, r_d, b_q, b_d, e_q, e_d;
    logic [BCW-1:0]   exp_cnt_q, exp_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [D_W-1:0]   out_data_q, out_data_d;
    logic [3:0]       out_n_q, out_n_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic [3:0]       key_n;
    logic [D_W-1:0]   key_e, key_m;
    logic [2*D_W-1:0] prod_rb, prod_bb, mod_w;
    logic [D_W-1:0]   rb_mod, bb_mod, data_mod;
    logic [SW-1:0]    sym_len;

    assign key_n    = key_q[KW-1 -: 4];
    assign key_e    = key_q[2*D_W-1:D_W];
    assign key_m    = key_q[D_W-1:0];
    assign mod_w    = {{D_W{1'b0}}, key_m};
    assign prod_rb  = {{D_W{1'b0}}, r_q} * {{D_W{1'b0}}, b_q};
    assign prod_bb  = {{D_W{1'b0}}, b_q} * {{D_W{1'b0}}, b_q};
    assign rb_mod   = D_W'(prod_rb % mod_w);
    assign bb_mod   = D_W'(prod_bb % mod_w);
    assign data_mod = data_q % key_m;
    assign sym_len  = {1'b0, c1_q} + {1'b0, c0_q};

    always_comb begin
        logic rx_err;
        rx_err      = 1'b0;
        state_d     = state_q;
        key_d       = key_q;
        ld_cnt_d    = ld_cnt_q;
        c1_d        = c1_q;
        c0_d        = c0_q;
        low_d       = low_q;
        data_d      = data_q;
        bit_cnt_d   = bit_cnt_q;
        r_d         = r_q;
        b_d         = b_q;
        e_d         = e_q;
        exp_cnt_d   = exp_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_n_d     = out_n_q;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mode) begin
                    key_d    = {{(KW-1){1'b0}}, str};
                    ld_cnt_d = LCW'(1);
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                if (!mode) begin
                    err_d    = 1'b1;
                    key_d    = '0;
                    ld_cnt_d = '0;
                    state_d  = StIdle;
                end else begin
                    key_d    = {key_q[KW-2:0], str};
                    ld_cnt_d = ld_cnt_q + LCW'(1);
                    if (ld_cnt_d == LCW'(KW)) begin
                        ld_cnt_d = '0;
                        if (key_d[KW-1 -: 4] > 4'(A) || key_d[D_W-1:0] < D_W'(2)) begin
                            err_d   = 1'b1;
                            key_d   = '0;
                            state_d = StIdle;
                        end else begin
                            state_d = StWaitMsg;
                        end
                    end
                end
            end
            StWaitMsg: begin
                if (mode) begin
                    key_d    = {{(KW-1){1'b0}}, str};
                    ld_cnt_d = LCW'(1);
                    state_d  = StLoad;
                end else if (str) begin
                    c1_d    = CW'(1);
                    c0_d    = '0;
                    low_d   = 1'b0;
                    state_d = StRxMsg;
                end
            end
            StRxMsg: begin
                if (mode) begin
                    rx_err = 1'b1;
                end else if (str && low_q) begin
                    // Rising edge after a low phase closes the symbol.
                    if (sym_len >= SymMinW && sym_len <= SymMaxW) begin
                        data_d    = {data_q[D_W-2:0], c1_q > c0_q};
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        c1_d      = CW'(1);
                        c0_d      = '0;
                        low_d     = 1'b0;
                        if (bit_cnt_d == (BCW'(1) << key_n)) begin
                            c1_d      = '0;
                            exp_cnt_d = '0;
                            state_d   = StExp;
                        end
                    end else begin
                        rx_err = 1'b1;
                    end
                end else if (str) begin
                    c1_d = (c1_q == '1) ? c1_q : c1_q + CW'(1);
                    if ({1'b0, c1_d} + {1'b0, c0_q} > SymMaxW) rx_err = 1'b1;
                end else begin
                    low_d = 1'b1;
                    c0_d  = (c0_q == '1) ? c0_q : c0_q + CW'(1);
                    if ({1'b0, c1_q} + {1'b0, c0_d} > SymMaxW) rx_err = 1'b1;
                end
                if (rx_err) begin
                    err_d     = 1'b1;
                    data_d    = '0;
                    bit_cnt_d = '0;
                    c1_d      = '0;
                    c0_d      = '0;
                    low_d     = 1'b0;
                    state_d   = StWaitMsg;
                end
            end
            StExp: begin
                // First cycle seeds the engine, then D_W square-and-multiply steps.
                if (exp_cnt_q == '0) begin
                    r_d       = D_W'(1);
                    b_d       = data_mod;
                    e_d       = key_e;
                    exp_cnt_d = BCW'(1);
                end else begin
                    if (e_q[0]) r_d = rb_mod;
                    b_d       = bb_mod;
                    e_d       = e_q >> 1;
                    exp_cnt_d = exp_cnt_q + BCW'(1);
                    if (exp_cnt_q == BCW'(D_W)) begin
                        exp_cnt_d   = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = r_d;
                        out_n_d     = key_n;
                        state_d     = StOut;
                    end
                end
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    data_d      = '0;
                    bit_cnt_d   = '0;
                    c1_d        = '0;
                    c0_d        = '0;
                    low_d       = 1'b0;
                    state_d     = StWaitMsg;
                end
            end
            default: state_d = StIdle;
        endcase

        // The commit edge itself does not raise busy; it rises one cycle into EXP.
        busy_d = (state_d == StExp && state_q == StExp) || state_d == StOut;
    end

`ifdef DECRX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            key_q       <= '0;
            ld_cnt_q    <= '0;
            c1_q        <= '0;
            c0_q        <= '0;
            low_q       <= 1'b0;
            data_q      <= '0;
            bit_cnt_q   <= '0;
            r_q         <= '0;
            b_q         <= '0;
            e_q         <= '0;
            exp_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_n_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            ld_cnt_q    <= ld_cnt_d;
            c1_q        <= c1_d;
            c0_q        <= c0_d;
            low_q       <= low_d;
            data_q      <= data_d;
            bit_cnt_q   <= bit_cnt_d;
            r_q         <= r_d;
            b_q         <= b_d;
            e_q         <= e_d;
            exp_cnt_q   <= exp_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_n_q     <= out_n_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_n     = out_n_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_decrypt_rx_param.sv
// Bench for decrypt_rx_param: stimulus tasks schedule per-edge expectations from the
// protocol rules; one compare process checks every edge against them.
module tb_decrypt_rx_param;

    localparam int A       = 5;
    localparam int D_W     = 32;
    localparam int SYM_MIN = 10;
    localparam int SYM_MAX = 60;
    localparam int MAXE    = 40000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mode = 1'b0;
    logic        str = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid, busy, err;
    logic [31:0] out_data;
    logic [3:0]  out_n;
`ifdef DECRX_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    decrypt_rx_param #(.A(A), .SYM_MIN(SYM_MIN), .SYM_MAX(SYM_MAX), .CW(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .str       (str),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_n     (out_n),
        .busy      (busy),
`ifdef DECRX_ERRCNT_EN
        .err_cnt   (err_cnt),
`endif
        .err       (err)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Expected outputs after each edge.
    bit          exp_err   [MAXE];
    bit          exp_busy  [MAXE];
    bit          exp_valid [MAXE];
    bit          exp_rst   [MAXE];
    logic [31:0] exp_data  [MAXE];
    logic [3:0]  exp_nv    [MAXE];

    int checks = 0;
    int errors = 0;
    int n_err_exp = 0;
    int cur = 0;
    int last_t = 0;
    int sym_h[$];
    int sym_l[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h required %0h", name, edge_n, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (edge_n < MAXE) begin
            if (exp_rst[edge_n]) begin
                chk("rst_data", out_data, 32'd0);
                chk("rst_n", 32'(out_n), 32'd0);
            end
            chk("err", 32'(err), 32'(exp_err[edge_n]));
            chk("busy", 32'(busy), 32'(exp_busy[edge_n]));
            chk("out_valid", 32'(out_valid), 32'(exp_valid[edge_n]));
            if (exp_valid[edge_n]) begin
                chk("out_data", out_data, exp_data[edge_n]);
                chk("out_n", 32'(out_n), 32'(exp_nv[edge_n]));
            end
            chk("err_and_valid", 32'(err & out_valid), 32'd0);
        end
    end

    task automatic tick(input logic m, input logic s, input logic r);
        @(negedge clk);
        reset = 1'b1;
        mode = m;
        str = s;
        out_ready = r;
        cur = edge_n + 1;
        if (cur >= MAXE - 2) begin
            $display("FAIL cycle_budget: got edge %0d required below %0d", cur, MAXE - 2);
            $fatal(1);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b0;
            mode = 1'b0;
            str = 1'b0;
            out_ready = 1'b0;
            cur = edge_n + 1;
            exp_rst[cur] = 1'b1;
        end
        n_err_exp = 0;
    endtask

    task automatic mark_err(input int k);
        exp_err[k] = 1'b1;
        n_err_exp++;
    endtask

    function automatic logic [31:0] modexp(input logic [31:0] m, input logic [31:0] e,
                                           input logic [31:0] nm);
        logic [63:0] r;
        logic [63:0] base;
        r = 64'd1;
        base = 64'(m % nm);
        for (int i = 31; i >= 0; i--) begin
            r = (r * r) % 64'(nm);
            if (e[i]) r = (r * base) % 64'(nm);
        end
        return r[31:0];
    endfunction

    task automatic load_key(input logic [3:0] n, input logic [31:0] d, input logic [31:0] nm);
        logic [67:0] kv;
        kv = {n, d, nm};
        for (int i = 67; i >= 0; i--) tick(1'b1, kv[i], 1'b0);
        if (!(n <= 4'(A) && nm >= 32'd2)) mark_err(cur);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_partial(input int nbits);
        for (int i = 0; i < nbits; i++) tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        mark_err(cur);
    endtask

    // A short symbol while IDLE must be ignored entirely.
    task automatic probe_idle();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_symbols(output bit ok);
        int nb;
        nb = sym_h.size();
        ok = 1'b0;
        for (int i = 0; i < nb; i++) begin
            for (int j = 0; j < sym_h[i]; j++) begin
                tick(1'b0, 1'b1, 1'b0);
                if (j == 0 && i > 0 && sym_h[i-1] + sym_l[i-1] < SYM_MIN) begin
                    mark_err(cur);
                    tick(1'b0, 1'b0, 1'b0);
                    return;
                end
                if (j + 1 > SYM_MAX) begin
                    mark_err(cur);
                    tick(1'b0, 1'b0, 1'b0);
                    return;
                end
            end
            for (int j = 0; j < sym_l[i]; j++) begin
                tick(1'b0, 1'b0, 1'b0);
                if (sym_h[i] + j + 1 > SYM_MAX) begin
                    mark_err(cur);
                    return;
                end
            end
        end
        tick(1'b0, 1'b1, 1'b0);
        if (sym_h[nb-1] + sym_l[nb-1] < SYM_MIN) begin
            mark_err(cur);
            tick(1'b0, 1'b0, 1'b0);
            return;
        end
        ok = 1'b1;
        last_t = cur;
    endtask

    task automatic dir_msg(input logic [3:0] bits);
        sym_h.delete();
        sym_l.delete();
        for (int i = 3; i >= 0; i--) begin
            sym_h.push_back(bits[i] ? 8 : 4);
            sym_l.push_back(bits[i] ? 4 : 8);
        end
    endtask

    task automatic gen_msg(input int nb, input int bad_at, output logic [31:0] data);
        int len, h, l;
        sym_h.delete();
        sym_l.delete();
        data = '0;
        for (int i = 0; i < nb; i++) begin
            if (i == bad_at) begin
                case ($urandom_range(0, 2))
                    0: begin
                        len = $urandom_range(2, SYM_MIN - 1);
                        h = $urandom_range(1, len - 1);
                        l = len - h;
                    end
                    1: begin
                        h = $urandom_range(SYM_MAX + 1, SYM_MAX + 8);
                        l = 4;
                    end
                    default: begin
                        len = $urandom_range(SYM_MAX + 1, SYM_MAX + 8);
                        h = $urandom_range(1, SYM_MAX - 1);
                        l = len - h;
                    end
                endcase
            end else begin
                len = $urandom_range(SYM_MIN, SYM_MAX);
                h = $urandom_range(1, len - 1);
                l = len - h;
            end
            sym_h.push_back(h);
            sym_l.push_back(l);
            data = {data[30:0], h > l};
        end
    endtask

    // Drives the EXP/OUT phase of a message whose last bit committed at edge t.
    task automatic finish_msg(input int t, input logic [31:0] expv, input logic [3:0] nv,
                              input int bp);
        int v, e, k;
        v = t + D_W + 1;
        e = v + bp + 1;
        while (cur < e) begin
            k = cur + 1;
            tick(1'b0, 1'($urandom_range(0, 1)),
                 (k == e) ? 1'b1 : ((k < v) ? 1'($urandom_range(0, 1)) : 1'b0));
            exp_busy[cur]  = (cur < e);
            exp_valid[cur] = (cur >= v && cur < e);
            exp_data[cur]  = expv;
            exp_nv[cur]    = nv;
        end
        tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit ok;
        int tries, bad_at, nb, t;
        logic [3:0]  rn;
        logic [31:0] rd, rm, data;

        do_reset(3);
        tick(1'b0, 1'b0, 1'b0);
        probe_idle();

        // Basic decrypt: n=2, d=3, N=33, bits 0101 -> 5^3 mod 33 = 26, with backpressure.
        load_key(4'd2, 32'd3, 32'd33);
        dir_msg(4'b0101);
        send_symbols(ok);
        finish_msg(last_t, 32'd26, 4'd2, 5);

        // Same key, bits 0010 -> 8.
        dir_msg(4'b0010);
        send_symbols(ok);
        finish_msg(last_t, 32'd8, 4'd2, 0);

        // Length-6 symbol errors; key retained: bits 1111 -> 15^3 mod 33 = 9.
        sym_h = '{3};
        sym_l = '{3};
        send_symbols(ok);
        dir_msg(4'b1111);
        send_symbols(ok);
        finish_msg(last_t, 32'd9, 4'd2, 2);

        // High run of 61 cycles times out on the 61st.
        sym_h = '{61};
        sym_l = '{5};
        send_symbols(ok);

        // mode raised in the middle of a symbol.
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        mark_err(cur);
        tick(1'b0, 1'b0, 1'b0);

        // Key errors: each leaves the block in IDLE.
        load_key(4'd6, 32'd3, 32'd33);
        probe_idle();
        load_key(4'd2, 32'd3, 32'd1);
        probe_idle();
        load_key(4'd2, 32'd3, 32'd33);
        load_partial(10);
        probe_idle();

        // Reset in the middle of exponentiation.
        load_key(4'd2, 32'd3, 32'd33);
        dir_msg(4'b1001);
        send_symbols(ok);
        t = last_t;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            exp_busy[cur] = (cur >= t + 1);
        end
        do_reset(1);
        probe_idle();

        // Randomised keys and messages.
        for (int kk = 0; kk < 6; kk++) begin
            rn = 4'($urandom_range(0, A));
            rd = $urandom;
            rm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(2, 60)) : $urandom;
            if (rm < 32'd2) rm = rm + 32'd2;
            load_key(rn, rd, rm);
            for (int mm = 0; mm < 2; mm++) begin
                ok = 1'b0;
                tries = 0;
                nb = 1 << rn;
                while (!ok) begin
                    bad_at = (tries < 2 && $urandom_range(0, 2) == 0) ?
                             int'($urandom_range(0, nb - 1)) : -1;
                    gen_msg(nb, bad_at, data);
                    send_symbols(ok);
                    tries++;
                    if (!ok) tick(1'b0, 1'b0, 1'b0);
                end
                finish_msg(last_t, modexp(data, rd, rm), rn, int'($urandom_range(0, 4)));
            end
        end

`ifdef DECRX_ERRCNT_EN
        for (int i = 0; i < 3; i++) begin
            sym_h = '{3};
            sym_l = '{3};
            send_symbols(ok);
        end
        tick(1'b0, 1'b0, 1'b0);
        chk("err_cnt_small", 32'(err_cnt), 32'((n_err_exp > 255) ? 255 : n_err_exp));
        for (int i = 0; i < 300; i++) begin
            sym_h = '{2};
            sym_l = '{2};
            send_symbols(ok);
        end
`endif

        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
`ifdef DECRX_ERRCNT_EN
        chk("err_cnt_sat", 32'(err_cnt), 32'((n_err_exp > 255) ? 255 : n_err_exp));
`endif
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
